manycore_mesh_node: RTL and testbench

// - One router tile of the manycore 2-D mesh: five ports (P=proc, W, E, N, S),

---
 rtl/manycore_mesh_node.sv | 163 ++++++++++++++++
 tb/tb_manycore_mesh_node.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/manycore_mesh_node.sv
// One router tile of the 2-D mesh: five ports with per-input FIFOs, X-then-Y
// dimension-ordered routing and a round-robin arbiter on every output.
module manycore_mesh_node #(
    parameter int          x_cord_width_p = 2,
    parameter int          y_cord_width_p = 2,
    parameter int          data_width_p   = 32,
    parameter int          fifo_els_p     = 2,
    parameter logic [3:0]  stub_p         = 4'b0000,
    localparam int         pkt_w_lp       = data_width_p + y_cord_width_p + x_cord_width_p
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic [3:0]                links_v_i,
    input  logic [4*pkt_w_lp-1:0]     links_data_i,
    output logic [3:0]                links_ready_o,
    output logic [3:0]                links_v_o,
    output logic [4*pkt_w_lp-1:0]     links_data_o,
    input  logic [3:0]                links_ready_i,
    input  logic                      proc_v_i,
    input  logic [pkt_w_lp-1:0]       proc_data_i,
    output logic                      proc_ready_o,
    output logic                      proc_v_o,
    output logic [pkt_w_lp-1:0]       proc_data_o,
    input  logic                      proc_ready_i
);

    // Port index 0=W 1=E 2=N 3=S 4=P, shared by inputs and outputs.
    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

    logic [4:0]          in_v;
    logic [pkt_w_lp-1:0] in_data [5];

    logic [pkt_w_lp-1:0] mem [5][fifo_els_p];
    logic [ptr_w_lp-1:0] wr_ptr [5];
    logic [ptr_w_lp-1:0] rd_ptr [5];
    logic [cnt_w_lp-1:0] count [5];
    logic [4:0]          full, nonempty, enq, deq;
    logic [pkt_w_lp-1:0] head [5];

    logic [4:0]          route [5];
    logic [4:0]          req [5];
    logic [2:0]          rr_ptr [5];
    logic [2:0]          gnt_idx [5];
    logic [4:0]          out_v, out_ready, fire;
    logic [pkt_w_lp-1:0] out_data [5];

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [2:0] rr_next(input logic [2:0] p, input logic [2:0] k);
        logic [3:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= 4'd5) s = s - 4'd5;
        return s[2:0];
    endfunction

    // Stubbed edge inputs never enqueue.
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            in_v[d]    = links_v_i[d] & ~stub_p[d];
            in_data[d] = links_data_i[d*pkt_w_lp +: pkt_w_lp];
        end
        in_v[4]    = proc_v_i;
        in_data[4] = proc_data_i;
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            full[i]     = (count[i] == cnt_w_lp'(fifo_els_p));
            nonempty[i] = (count[i] != '0);
            head[i]     = mem[i][rd_ptr[i]];
            enq[i]      = in_v[i] & ~full[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            route[i] = '0;
            if (head[i][x_cord_width_p-1:0] < my_x_i)
                route[i][0] = 1'b1;
            else if (head[i][x_cord_width_p-1:0] > my_x_i)
                route[i][1] = 1'b1;
            else if (head[i][x_cord_width_p +: y_cord_width_p] < my_y_i)
                route[i][2] = 1'b1;
            else if (head[i][x_cord_width_p +: y_cord_width_p] > my_y_i)
                route[i][3] = 1'b1;
            else
                route[i][4] = 1'b1;
        end
    end

    // Scan from the pointer outward; the last hit in a descending scan is the nearest.
    always_comb begin
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++)
                req[o][i] = nonempty[i] & route[i][o];
            gnt_idx[o] = rr_ptr[o];
            for (int k = 4; k >= 0; k--) begin
                if (req[o][rr_next(rr_ptr[o], 3'(k))])
                    gnt_idx[o] = rr_next(rr_ptr[o], 3'(k));
            end
            out_v[o]    = |req[o];
            out_data[o] = out_v[o] ? head[gnt_idx[o]] : '0;
        end
        for (int d = 0; d < 4; d++)
            out_ready[d] = stub_p[d] | links_ready_i[d];
        out_ready[4] = proc_ready_i;
        fire = out_v & out_ready;
    end

    always_comb begin
        deq = '0;
        for (int o = 0; o < 5; o++)
            for (int i = 0; i < 5; i++)
                if (fire[o] && gnt_idx[o] == 3'(i))
                    deq[i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < 5; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
                rr_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (enq[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (deq[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                if (enq[i] && !deq[i])
                    count[i] <= count[i] + 1'b1;
                else if (deq[i] && !enq[i])
                    count[i] <= count[i] - 1'b1;
                if (fire[i]) rr_ptr[i] <= rr_next(gnt_idx[i], 3'd1);
            end
        end
    end

    // Payload storage needs no reset; validity lives in the counters.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 5; i++)
            if (enq[i]) mem[i][wr_ptr[i]] <= in_data[i];
    end

    always_comb begin
        links_data_o = '0;
        for (int d = 0; d < 4; d++) begin
            links_ready_o[d] = stub_p[d] | ~full[d];
            links_v_o[d]     = out_v[d] & ~stub_p[d];
            if (!stub_p[d])
                links_data_o[d*pkt_w_lp +: pkt_w_lp] = out_data[d];
        end
        proc_ready_o = ~full[4];
        proc_v_o     = out_v[4];
        proc_data_o  = out_data[4];
    end

endmodule

// File: tb/tb_manycore_mesh_node.sv
// Directed bench for manycore_mesh_node at node (1,1): routing, round-robin,
// backpressure, stubbed edge port and reset with buffered packets.
module tb_manycore_mesh_node;

    localparam int PW = 36;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [1:0]    my_x_i, my_y_i;
    logic [3:0]    links_v_i, links_ready_o, links_v_o, links_ready_i;
    logic [4*PW-1:0] links_data_i, links_data_o;
    logic          proc_v_i, proc_ready_o, proc_v_o, proc_ready_i;
    logic [PW-1:0] proc_data_i, proc_data_o;

    logic [3:0]    s_links_v_i, s_links_ready_o, s_links_v_o, s_links_ready_i;
    logic [4*PW-1:0] s_links_data_i, s_links_data_o;
    logic          s_proc_v_i, s_proc_ready_o, s_proc_v_o, s_proc_ready_i;
    logic [PW-1:0] s_proc_data_i, s_proc_data_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    manycore_mesh_node dut (
        .clk_i(clk_i), .reset_i(reset_i), .my_x_i(my_x_i), .my_y_i(my_y_i),
        .links_v_i(links_v_i), .links_data_i(links_data_i), .links_ready_o(links_ready_o),
        .links_v_o(links_v_o), .links_data_o(links_data_o), .links_ready_i(links_ready_i),
        .proc_v_i(proc_v_i), .proc_data_i(proc_data_i), .proc_ready_o(proc_ready_o),
        .proc_v_o(proc_v_o), .proc_data_o(proc_data_o), .proc_ready_i(proc_ready_i)
    );

    manycore_mesh_node #(.stub_p(4'b0001)) dut_stub (
        .clk_i(clk_i), .reset_i(reset_i), .my_x_i(my_x_i), .my_y_i(my_y_i),
        .links_v_i(s_links_v_i), .links_data_i(s_links_data_i), .links_ready_o(s_links_ready_o),
        .links_v_o(s_links_v_o), .links_data_o(s_links_data_o), .links_ready_i(s_links_ready_i),
        .proc_v_i(s_proc_v_i), .proc_data_i(s_proc_data_i), .proc_ready_o(s_proc_ready_o),
        .proc_v_o(s_proc_v_o), .proc_data_o(s_proc_data_o), .proc_ready_i(s_proc_ready_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [PW-1:0] pkt(input int x, input int y, input logic [31:0] d);
        return {d, 2'(y), 2'(x)};
    endfunction

    function automatic logic [PW-1:0] slot(input logic [4*PW-1:0] bus, input int d);
        return bus[d*PW +: PW];
    endfunction

    task tick;
        @(posedge clk_i);
        #1;
    endtask

    task pulse_reset;
        reset_i = 1'b0;
        #2;
        reset_i = 1'b1;
    endtask

    logic [PW-1:0] q [4][$];
    logic [PW-1:0] p0, p1, p2;
    int seq [4];
    int rot, exp_d, dd, grants, accepted;

    initial begin
        reset_i = 1'b0;
        my_x_i = 2'd1; my_y_i = 2'd1;
        links_v_i = '0; links_data_i = '0; links_ready_i = 4'hf;
        proc_v_i = 1'b0; proc_data_i = '0; proc_ready_i = 1'b1;
        s_links_v_i = '0; s_links_data_i = '0; s_links_ready_i = 4'hf;
        s_proc_v_i = 1'b0; s_proc_data_i = '0; s_proc_ready_i = 1'b1;

        tick; tick;
        chk("rst_links_v", links_v_o, 4'h0);
        chk("rst_proc_v", proc_v_o, 1'b0);
        chk("rst_links_data", 64'(|links_data_o), 0);
        chk("rst_proc_data", proc_data_o, 0);
        reset_i = 1'b1;
        #1;
        chk("rel_links_ready", links_ready_o, 4'hf);
        chk("rel_proc_ready", proc_ready_o, 1'b1);

        // Proc injection x=2,y=1 goes east one cycle later.
        p0 = pkt(2, 1, 32'hA000_0001);
        proc_v_i = 1'b1; proc_data_i = p0;
        #1 chk("inj_ready", proc_ready_o, 1'b1);
        tick;
        proc_v_i = 1'b0;
        chk("inj_e_v", links_v_o, 4'b0010);
        chk("inj_e_data", slot(links_data_o, 1), p0);
        chk("inj_ready_after", proc_ready_o, 1'b1);
        tick;
        chk("inj_e_gone", links_v_o, 4'b0000);

        // X is resolved before Y: x=0,y=3 must go west, x=1,y=3 south.
        p0 = pkt(0, 3, 32'hA000_0002);
        proc_v_i = 1'b1; proc_data_i = p0;
        tick;
        proc_v_i = 1'b0;
        chk("xy_w_v", links_v_o, 4'b0001);
        chk("xy_w_data", slot(links_data_o, 0), p0);
        tick;
        p0 = pkt(1, 3, 32'hA000_0003);
        proc_v_i = 1'b1; proc_data_i = p0;
        tick;
        proc_v_i = 1'b0;
        chk("xy_s_v", links_v_o, 4'b1000);
        chk("xy_s_data", slot(links_data_o, 3), p0);
        tick;

        // W input to north, then to local ejection.
        p0 = pkt(1, 0, 32'hB000_0001);
        links_v_i[0] = 1'b1; links_data_i[0 +: PW] = p0;
        tick;
        links_v_i = '0;
        chk("w_to_n_v", links_v_o, 4'b0100);
        chk("w_to_n_data", slot(links_data_o, 2), p0);
        tick;
        p0 = pkt(1, 1, 32'hB000_0002);
        links_v_i[0] = 1'b1; links_data_i[0 +: PW] = p0;
        tick;
        links_v_i = '0;
        chk("w_to_p_v", proc_v_o, 1'b1);
        chk("w_to_p_data", proc_data_o, p0);
        tick;

        // All four links stream to proc; grants rotate W,E,N,S with no loss.
        pulse_reset;
        rot = 0; grants = 0; accepted = 0;
        for (int d = 0; d < 4; d++) seq[d] = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            for (int d = 0; d < 4; d++) begin
                links_v_i[d] = (cyc < 14);
                links_data_i[d*PW +: PW] = pkt(1, 1, {8'(d), 24'(seq[d])});
            end
            #1;
            if (proc_v_o) begin
                exp_d = -1;
                for (int k = 0; k < 4; k++) begin
                    dd = (rot + k) % 4;
                    if (exp_d < 0 && q[dd].size() != 0) exp_d = dd;
                end
                if (exp_d < 0)
                    chk("rr_spurious", proc_v_o, 1'b0);
                else begin
                    chk("rr_data", proc_data_o, q[exp_d].pop_front());
                    rot = (exp_d + 1) % 4;
                    grants++;
                end
            end
            for (int d = 0; d < 4; d++) begin
                if (links_v_i[d] && links_ready_o[d]) begin
                    q[d].push_back(links_data_i[d*PW +: PW]);
                    seq[d]++;
                    accepted++;
                end
            end
            tick;
        end
        links_v_i = '0;
        chk("rr_left", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
        chk("rr_count", grants, accepted);

        // East stalled: proc FIFO fills after two, head stays put, drains in order.
        pulse_reset;
        links_ready_i = 4'b1101;
        p0 = pkt(2, 0, 32'hC000_0000);
        p1 = pkt(2, 1, 32'hC000_0001);
        p2 = pkt(3, 2, 32'hC000_0002);
        proc_v_i = 1'b1; proc_data_i = p0;
        #1 chk("bp_rdy0", proc_ready_o, 1'b1);
        tick;
        proc_data_i = p1;
        chk("bp_rdy1", proc_ready_o, 1'b1);
        tick;
        proc_data_i = p2;
        chk("bp_full", proc_ready_o, 1'b0);
        chk("bp_head0", slot(links_data_o, 1), p0);
        tick;
        chk("bp_full_hold", proc_ready_o, 1'b0);
        chk("bp_head_stable", slot(links_data_o, 1), p0);
        chk("bp_e_v", links_v_o, 4'b0010);
        tick;
        links_ready_i = 4'hf;
        #1 chk("bp_drain0", slot(links_data_o, 1), p0);
        tick;
        chk("bp_drain1", slot(links_data_o, 1), p1);
        chk("bp_rdy_again", proc_ready_o, 1'b1);
        tick;
        proc_v_i = 1'b0;
        chk("bp_drain2", slot(links_data_o, 1), p2);
        tick;
        chk("bp_empty", links_v_o, 4'b0000);

        // Stubbed west: ignored input, dropped output, always ready.
        chk("stub_rdy", s_links_ready_o[0], 1'b1);
        s_links_v_i[0] = 1'b1; s_links_data_i[0 +: PW] = pkt(2, 1, 32'hD000_0000);
        for (int n = 0; n < 3; n++) begin
            s_proc_v_i = 1'b1; s_proc_data_i = pkt(0, 1, 32'hD000_0010 + 32'(n));
            #1 chk("stub_proc_rdy", s_proc_ready_o, 1'b1);
            tick;
            chk("stub_v", s_links_v_o, 4'b0000);
            chk("stub_data", slot(s_links_data_o, 0), 0);
        end
        s_proc_v_i = 1'b0; s_links_v_i = '0;
        tick;
        chk("stub_rdy_end", s_links_ready_o[0], 1'b1);
        p0 = pkt(2, 1, 32'hD000_0020);
        s_proc_v_i = 1'b1; s_proc_data_i = p0;
        tick;
        s_proc_v_i = 1'b0;
        chk("stub_after_v", s_links_v_o, 4'b0010);
        chk("stub_after_data", slot(s_links_data_o, 1), p0);
        tick;

        // Reset with every FIFO full drops everything immediately.
        links_ready_i = 4'h0; proc_ready_i = 1'b0;
        links_v_i = 4'hf; proc_v_i = 1'b1;
        links_data_i[0*PW +: PW] = pkt(2, 1, 32'hE000_0000);
        links_data_i[1*PW +: PW] = pkt(0, 1, 32'hE000_0001);
        links_data_i[2*PW +: PW] = pkt(1, 2, 32'hE000_0002);
        links_data_i[3*PW +: PW] = pkt(1, 0, 32'hE000_0003);
        proc_data_i = pkt(1, 1, 32'hE000_0004);
        tick; tick;
        links_v_i = '0; proc_v_i = 1'b0;
        chk("full_links_v", links_v_o, 4'hf);
        chk("full_proc_v", proc_v_o, 1'b1);
        chk("full_links_rdy", links_ready_o, 4'h0);
        chk("full_proc_rdy", proc_ready_o, 1'b0);
        reset_i = 1'b0;
        #1;
        chk("mid_rst_links_v", links_v_o, 4'h0);
        chk("mid_rst_proc_v", proc_v_o, 1'b0);
        chk("mid_rst_data", 64'(|links_data_o), 0);
        reset_i = 1'b1;
        links_ready_i = 4'hf; proc_ready_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("post_rst_links_v", links_v_o, 4'h0);
            chk("post_rst_proc_v", proc_v_o, 1'b0);
            tick;
        end
        chk("post_rst_rdy", {links_ready_o, proc_ready_o}, 5'h1f);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
